waveform_analyzer: RTL and testbench

- Consumes the 8-bit sample stream produced by the lab waveform generator and characterises one period at a time.
- Detects rising mid-scale crossings with hysteresis and measures the period in enabled clock cycles.
- Tracks the minimum, maximum and peak-to-peak sample value over each period.
- Publishes each result with a one-cycle valid pulse, for the display/scope-readout path.

---
 rtl/waveform_analyzer.sv | 143 ++++++++++++++
 tb/tb_waveform_analyzer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_analyzer.sv
// Period and amplitude analyser for an 8-bit sample stream.
// Finds hysteretic rising mid-scale crossings, then publishes period/min/max/p2p.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         sample strobe, sample consumed only when en=1
//   sample     unsigned 8-bit waveform sample
//   period     last measured period in en-cycles
//   min_val    minimum sample of the last period
//   max_val    maximum sample of the last period
//   p2p        max_val - min_val
//   meas_valid one-cycle pulse when a new measurement is published
//   timeout    sticky, set when no rising crossing fits in the counter range
module waveform_analyzer #(
   parameter int MID   = 128,
   parameter int HYST  = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [7:0]       sample,
   output logic [CNT_W-1:0] period,
   output logic [7:0]       min_val,
   output logic [7:0]       max_val,
   output logic [7:0]       p2p,
   output logic             meas_valid,
   output logic             timeout
);

   localparam logic [7:0]       TH_HI   = 8'(MID + HYST);
   localparam logic [7:0]       TH_LO   = 8'(MID - HYST);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      RUN_HIGH,
      RUN_LOW
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       run_min;
   logic [7:0]       run_max;

   logic hi;
   logic lo;
   logic at_max;
   logic running;
   logic start;
   logic publish;
   logic expire;
   logic accum;

   assign hi      = (sample >= TH_HI);
   assign lo      = (sample <= TH_LO);
   assign at_max  = (cnt == CNT_MAX);
   assign running = (state == RUN_HIGH) || (state == RUN_LOW);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A rising crossing in RUN_LOW wins over an expiring counter.
   always_comb begin
      state_nxt = state;
      if (en) begin
         case (state)
            IDLE:     if (lo) state_nxt = ARM;
            ARM:      if (hi) state_nxt = RUN_HIGH;
            RUN_HIGH: begin
               if (at_max)  state_nxt = IDLE;
               else if (lo) state_nxt = RUN_LOW;
            end
            RUN_LOW: begin
               if (hi)          state_nxt = RUN_HIGH;
               else if (at_max) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
         endcase
      end
   end

   // Datapath strobes; every non-publishing, non-expiring running
   // cycle (falling crossings included) counts towards the period.
   always_comb begin
      start   = 1'b0;
      publish = 1'b0;
      expire  = 1'b0;
      accum   = 1'b0;
      if (en) begin
         start   = (state == ARM) && hi;
         publish = (state == RUN_LOW) && hi;
         expire  = running && at_max && !publish;
         accum   = running && !publish && !expire;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         run_min    <= '0;
         run_max    <= '0;
         period     <= '0;
         min_val    <= '0;
         max_val    <= '0;
         p2p        <= '0;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         meas_valid <= publish;
         if (publish) begin
            period  <= cnt;
            min_val <= run_min;
            max_val <= run_max;
            p2p     <= run_max - run_min;
            timeout <= 1'b0;
         end
         if (start || publish) begin
            cnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
            run_min <= sample;
            run_max <= sample;
         end
         if (expire) begin
            cnt     <= '0;
            timeout <= 1'b1;
         end
         if (accum) begin
            cnt <= cnt + 1'b1;
            if (sample < run_min) run_min <= sample;
            if (sample > run_max) run_max <= sample;
         end
      end
   end

endmodule

// File: tb/tb_waveform_analyzer.sv
// Scoreboard bench for waveform_analyzer: stimulus pushes expected
// publishes, a forked monitor pops and compares on every meas_valid.
module tb_waveform_analyzer;

   logic        clk;
   logic        rst;
   logic        en;
   logic [7:0]  sample;
   logic [15:0] period;
   logic [7:0]  min_val;
   logic [7:0]  max_val;
   logic [7:0]  p2p;
   logic        meas_valid;
   logic        timeout;

   typedef struct {
      int per;
      int mn;
      int mx;
      int pp;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   errors;
   int   cycle;

   waveform_analyzer dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sample     (sample),
      .period     (period),
      .min_val    (min_val),
      .max_val    (max_val),
      .p2p        (p2p),
      .meas_valid (meas_valid),
      .timeout    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic drive(input int e, input int s);
      @(negedge clk);
      en     = 1'(e);
      sample = 8'(s);
   endtask

   // Call right after driving the crossing sample that must publish.
   task automatic expect_pub(input int p, input int mn, input int mx);
      exp_t e;
      e.per = p;
      e.mn  = mn;
      e.mx  = mx;
      e.pp  = mx - mn;
      e.cyc = cycle + 1;
      q.push_back(e);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period"}, int'(period), 0);
      chk({tag, "_min"}, int'(min_val), 0);
      chk({tag, "_max"}, int'(max_val), 0);
      chk({tag, "_p2p"}, int'(p2p), 0);
      chk({tag, "_valid"}, int'(meas_valid), 0);
      chk({tag, "_timeout"}, int'(timeout), 0);
   endtask

   task automatic chk_hold(input string tag, input int p, input int to);
      chk({tag, "_period"}, int'(period), p);
      chk({tag, "_min"}, int'(min_val), 0);
      chk({tag, "_max"}, int'(max_val), 255);
      chk({tag, "_p2p"}, int'(p2p), 255);
      chk({tag, "_timeout"}, int'(timeout), to);
   endtask

   task automatic do_reset();
      @(negedge clk);
      en = 1'b0;
      #1;
      chk("sb_drained", q.size(), 0);
      rst = 1'b1;
      #1;
      chk("async_rst_period", int'(period), 0);
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   // 8 low, 8 high, 8 low, one high: publishes period 16.
   task automatic short_square();
      for (int i = 0; i < 8; i++) drive(1, 0);
      for (int i = 0; i < 8; i++) drive(1, 255);
      for (int i = 0; i < 8; i++) drive(1, 0);
      drive(1, 255);
      expect_pub(16, 0, 255);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && meas_valid) begin
            chk("exp_pending", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("pub_period", int'(period), e.per);
               chk("pub_min", int'(min_val), e.mn);
               chk("pub_max", int'(max_val), e.mx);
               chk("pub_p2p", int'(p2p), e.pp);
               chk("pub_cycle", cycle, e.cyc);
               chk("pub_timeout", int'(timeout), 0);
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      en     = 1'b0;
      sample = 8'd0;
      fork
         monitor();
      join_none
      #2;
      chk_zero("reset");
      @(negedge clk);
      #1 rst = 1'b0;

      // Square 128/128, four repeats: three publishes 256 clocks apart.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 128; i++) drive(1, 0);
         for (int i = 0; i < 128; i++) begin
            drive(1, 255);
            if (r > 0 && i == 0) expect_pub(256, 0, 255);
         end
      end

      // Sawtooth: crossing lands on sample 136 each sweep.
      do_reset();
      for (int sw = 0; sw < 3; sw++) begin
         for (int v = 0; v < 256; v++) begin
            drive(1, v);
            if (sw > 0 && v == 136) expect_pub(256, 0, 255);
         end
      end

      // en toggling, 64 en-cycle periods, garbage on idle cycles.
      do_reset();
      for (int p = 0; p < 10; p++) begin
         for (int i = 0; i < 64; i++) begin
            drive(1, (i < 32) ? 0 : 255);
            if (p > 0 && i == 32) expect_pub(64, 0, 255);
            drive(0, int'($urandom_range(0, 255)));
         end
      end

      // Dither inside the hysteresis band after one full period.
      do_reset();
      for (int i = 0; i < 64; i++) drive(1, 0);
      for (int i = 0; i < 64; i++) drive(1, 255);
      for (int i = 0; i < 64; i++) drive(1, 0);
      drive(1, 255);
      expect_pub(128, 0, 255);
      for (int i = 0; i < 1000; i++) drive(1, (i % 2 == 0) ? 125 : 131);
      drive(0, 0);
      #1;
      chk_hold("dither_hold", 128, 0);
      drive(1, 0);
      drive(1, 255);
      expect_pub(1002, 0, 255);

      // Counter expiry while parked high.
      do_reset();
      short_square();
      for (int k = 1; k <= 65534; k++) drive(1, 200);
      drive(1, 200);
      #1;
      chk("timeout_early", int'(timeout), 0);
      drive(0, 0);
      #1;
      chk_hold("timeout_set", 16, 1);
      short_square();
      drive(0, 0);
      drive(0, 0);
      #1;
      chk_hold("timeout_clr", 16, 0);

      // Asynchronous reset in mid-period.
      do_reset();
      short_square();
      for (int i = 0; i < 5; i++) drive(1, 255);
      @(posedge clk);
      #2;
      rst = 1'b1;
      en  = 1'b0;
      #1;
      chk_zero("mid_rst");
      @(negedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) drive(1, 255);
      short_square();

      repeat (3) drive(0, 0);
      #1;
      chk("final_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
